// File: rtl/aes_round_sequencer.sv
// ============================================================================
// Module   : aes_round_sequencer
// Purpose  : Control sequencer for an iterative AES datapath. It holds the
//            128-bit cipher state and steps it through the external
//            AddRoundKey / SubBytes / ShiftRows / MixColumns units. Encrypt or
//            decrypt order is selected by Mode. Each unit is started with its
//            enable and finished by its ready strobe.
// Ports    : Clk, Rst        - clock, synchronous active-high reset
//            En, Mode, DataIn - start request, direction, input block
//            DataOut, Ry     - result block and one-cycle completion pulse
//            Busy, Inv       - run in progress, latched direction for units
//            SelKey, Text    - round-key index, operand to the units
//            ModifiedText    - result returned by the active unit
//            *En / *Ry       - per-unit enable and ready handshake
//            Err             - sticky flag for a ready from an idle unit
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_round_sequencer #(
    parameter int NR = 10,
    parameter int DW = 128
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          En,
    input  logic          Mode,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut,
    output logic          Ry,
    output logic          Busy,
    output logic          Inv,
    output logic [3:0]    SelKey,
    output logic [DW-1:0] Text,
    input  logic [DW-1:0] ModifiedText,
    output logic          AddEn,
    output logic          SubEn,
    output logic          ShiftEn,
    output logic          MixEn,
    input  logic          AddRy,
    input  logic          SubRy,
    input  logic          ShiftRy,
    input  logic          MixRy,
    output logic          Err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SUB   = 3'd3,
        S_SHIFT = 3'd4,
        S_MIX   = 3'd5,
        S_GAP   = 3'd6,
        S_DONE  = 3'd7
    } fsmState_t;

    localparam logic [3:0] c_NR = 4'(NR);

    fsmState_t     r_fsm;
    fsmState_t     w_fsmNext;
    fsmState_t     w_nextOp;
    logic [DW-1:0] r_text;
    logic [DW-1:0] r_dataOut;
    logic [3:0]    r_round;     // round counter r
    logic [1:0]    r_phase;     // op position inside the current round
    logic          r_lastDone;  // final op completed; GAP leads to DONE
    logic          r_inv;
    logic          r_err;
    logic          r_ry;
    logic          w_start;
    logic          w_opDone;
    logic          w_isLastOp;
    logic          w_stray;
    logic          w_addEn;
    logic          w_subEn;
    logic          w_shiftEn;
    logic          w_mixEn;

    // Mode and DataIn are captured on the edge that accepts the start, so
    // anything they do once Busy is high cannot reach the run.
    assign w_start    = (r_fsm == S_IDLE) && En;
    assign w_isLastOp = (r_round == c_NR) && (r_phase == 2'd2);

    // Op to run after LOAD or GAP. Round 0 is the lone initial ADD; rounds
    // 1..NR have four ops each, except the final round, which skips MIX
    // (encrypt) or ends on its ADD (decrypt).
    always_comb begin
        w_nextOp = S_ADD;
        if (r_round != 4'd0) begin
            if (!r_inv) begin
                case (r_phase)
                    2'd0:    w_nextOp = S_SUB;
                    2'd1:    w_nextOp = S_SHIFT;
                    2'd2:    w_nextOp = (r_round == c_NR) ? S_ADD : S_MIX;
                    default: w_nextOp = S_ADD;
                endcase
            end else begin
                case (r_phase)
                    2'd0:    w_nextOp = S_SHIFT;
                    2'd1:    w_nextOp = S_SUB;
                    2'd2:    w_nextOp = S_ADD;
                    default: w_nextOp = S_MIX;
                endcase
            end
        end
    end

    always_comb begin
        w_fsmNext = r_fsm;
        w_addEn   = 1'b0;
        w_subEn   = 1'b0;
        w_shiftEn = 1'b0;
        w_mixEn   = 1'b0;
        w_opDone  = 1'b0;
        case (r_fsm)
            S_IDLE:  if (En) w_fsmNext = S_LOAD;
            S_LOAD:  w_fsmNext = w_nextOp;
            S_ADD: begin
                w_addEn = 1'b1;
                if (AddRy) begin
                    w_opDone  = 1'b1;
                    w_fsmNext = S_GAP;
                end
            end
            S_SUB: begin
                w_subEn = 1'b1;
                if (SubRy) begin
                    w_opDone  = 1'b1;
                    w_fsmNext = S_GAP;
                end
            end
            S_SHIFT: begin
                w_shiftEn = 1'b1;
                if (ShiftRy) begin
                    w_opDone  = 1'b1;
                    w_fsmNext = S_GAP;
                end
            end
            S_MIX: begin
                w_mixEn = 1'b1;
                if (MixRy) begin
                    w_opDone  = 1'b1;
                    w_fsmNext = S_GAP;
                end
            end
            S_GAP:   w_fsmNext = r_lastDone ? S_DONE : w_nextOp;
            S_DONE:  w_fsmNext = S_IDLE;
            default: w_fsmNext = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsmNext;
    end

    // Any ready whose unit is not currently enabled is a protocol error.
    assign w_stray = (AddRy   & ~w_addEn)   | (SubRy & ~w_subEn) |
                     (ShiftRy & ~w_shiftEn) | (MixRy & ~w_mixEn);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_text     <= '0;
            r_dataOut  <= '0;
            r_round    <= 4'd0;
            r_phase    <= 2'd0;
            r_lastDone <= 1'b0;
            r_inv      <= 1'b0;
            r_err      <= 1'b0;
            r_ry       <= 1'b0;
        end else begin
            // Ry is registered: it rises on the DONE->IDLE edge with DataOut.
            r_ry <= (r_fsm == S_DONE);
            if (r_fsm == S_DONE) r_dataOut <= r_text;

            if (w_start) begin
                r_text     <= DataIn;
                r_inv      <= Mode;
                r_round    <= 4'd0;
                r_phase    <= 2'd0;
                r_lastDone <= 1'b0;
            end

            // The counters move on the op-completion edge so that GAP already
            // presents the key index of the next ADD on SelKey.
            if (w_opDone) begin
                r_text <= ModifiedText;
                if (w_isLastOp) begin
                    r_lastDone <= 1'b1;
                end else if ((r_round == 4'd0) || (r_phase == 2'd3)) begin
                    r_round <= r_round + 4'd1;
                    r_phase <= 2'd0;
                end else begin
                    r_phase <= r_phase + 2'd1;
                end
            end

            if (r_fsm == S_LOAD) r_err <= w_stray;
            else if (w_stray)    r_err <= 1'b1;
        end
    end

    // Decrypt walks the keys downward; after a decrypt ADD (phase 3, the MIX
    // half of the round) the next ADD is already one key lower.
    assign SelKey  = r_inv ? (c_NR - r_round - {3'd0, (r_phase == 2'd3)}) : r_round;
    assign Busy    = (r_fsm != S_IDLE);
    assign Text    = r_text;
    assign DataOut = r_dataOut;
    assign Ry      = r_ry;
    assign Inv     = r_inv;
    assign Err     = r_err;
    assign AddEn   = w_addEn;
    assign SubEn   = w_subEn;
    assign ShiftEn = w_shiftEn;
    assign MixEn   = w_mixEn;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
// ============================================================================
// Module   : tb_aes_round_sequencer
// Purpose  : Self-checking bench for aes_round_sequencer. A responder process
//            models the four units with distinct, non-commuting transforms.
//            The reference model walks the encrypt/decrypt op order with plain
//            loops to predict DataOut. The driver pushes each prediction into
//            a scoreboard queue, and a monitor pops and compares on every Ry.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_round_sequencer;

    localparam int NR = 10;
    localparam int DW = 128;
    localparam int OP_ADD = 0, OP_SUB = 1, OP_SHIFT = 2, OP_MIX = 3;

    logic          Clk = 1'b0;
    logic          Rst, En, Mode;
    logic [DW-1:0] DataIn, DataOut, Text, ModifiedText;
    logic          Ry, Busy, Inv, Err;
    logic [3:0]    SelKey;
    logic          AddEn, SubEn, ShiftEn, MixEn;
    logic          AddRy, SubRy, ShiftRy, MixRy;

    aes_round_sequencer #(.NR(NR), .DW(DW)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .DataIn(DataIn),
        .DataOut(DataOut), .Ry(Ry), .Busy(Busy), .Inv(Inv), .SelKey(SelKey),
        .Text(Text), .ModifiedText(ModifiedText),
        .AddEn(AddEn), .SubEn(SubEn), .ShiftEn(ShiftEn), .MixEn(MixEn),
        .AddRy(AddRy), .SubRy(SubRy), .ShiftRy(ShiftRy), .MixRy(MixRy),
        .Err(Err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cycCount = 0;
    always @(posedge Clk) cycCount++;

    typedef struct {
        logic [DW-1:0] data;
        bit            err;
        int            startCyc;
        int            expLat;
    } exp_t;
    exp_t sbq[$];

    // Run configuration shared with the responder
    int gUnitMode  = 0;   // 0 scramble, 1 identity, 2 increment
    int gDelayMax  = 0;
    bit gDelayRand = 1'b0;
    bit gStrayReq  = 1'b0;
    int gRunId     = 0;
    bit curMode    = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] randBlock();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] keyPat(input int k);
        logic [7:0] b;
        b = 8'(k * 29 + 91);
        return {(DW/8){b}};
    endfunction

    function automatic logic [DW-1:0] unitFn(input int op, input logic [DW-1:0] t,
                                             input int k, input int um);
        if (um == 1) return t;
        if (um == 2) return t + DW'(1);
        case (op)
            OP_ADD:   return t ^ keyPat(k);
            OP_SUB:   return t + DW'(1);
            OP_SHIFT: return {t[DW-9:0], t[DW-1:DW-8]};
            default:  return t ^ (t >> 3);
        endcase
    endfunction

    // Op order straight from the cipher definition: encrypt and decrypt.
    function automatic logic [DW-1:0] refModel(input bit mode, input logic [DW-1:0] din, input int um);
        logic [DW-1:0] t;
        t = din;
        if (!mode) begin
            t = unitFn(OP_ADD, t, 0, um);
            for (int r = 1; r < NR; r++) begin
                t = unitFn(OP_SUB, t, 0, um);
                t = unitFn(OP_SHIFT, t, 0, um);
                t = unitFn(OP_MIX, t, 0, um);
                t = unitFn(OP_ADD, t, r, um);
            end
            t = unitFn(OP_SUB, t, 0, um);
            t = unitFn(OP_SHIFT, t, 0, um);
            t = unitFn(OP_ADD, t, NR, um);
        end else begin
            t = unitFn(OP_ADD, t, NR, um);
            for (int r = 1; r < NR; r++) begin
                t = unitFn(OP_SHIFT, t, 0, um);
                t = unitFn(OP_SUB, t, 0, um);
                t = unitFn(OP_ADD, t, NR - r, um);
                t = unitFn(OP_MIX, t, 0, um);
            end
            t = unitFn(OP_SHIFT, t, 0, um);
            t = unitFn(OP_SUB, t, 0, um);
            t = unitFn(OP_ADD, t, 0, um);
        end
        return t;
    endfunction

    // Unit responder: answers the active enable after a delay, and once per
    // requested run pulses MixRy during a SUB op as a stray ready.
    int rspOp;
    int rspWait = 0;
    bit rspInOp = 1'b0;
    int rspStrayRun = -1;
    always @(negedge Clk) begin
        AddRy = 1'b0; SubRy = 1'b0; ShiftRy = 1'b0; MixRy = 1'b0;
        rspOp = AddEn ? OP_ADD : SubEn ? OP_SUB : ShiftEn ? OP_SHIFT : MixEn ? OP_MIX : -1;
        if (Rst || rspOp < 0) begin
            rspInOp = 1'b0;
            ModifiedText = ~Text;
        end else begin
            if (!rspInOp) begin
                rspInOp = 1'b1;
                rspWait = gDelayRand ? int'($urandom_range(gDelayMax, 0)) : gDelayMax;
            end
            if (rspWait == 0) begin
                if (rspOp == OP_ADD)        AddRy   = 1'b1;
                else if (rspOp == OP_SUB)   SubRy   = 1'b1;
                else if (rspOp == OP_SHIFT) ShiftRy = 1'b1;
                else                        MixRy   = 1'b1;
                ModifiedText = unitFn(rspOp, Text, int'(SelKey), gUnitMode);
                rspInOp = 1'b0;
            end else begin
                rspWait--;
                ModifiedText = ~Text;
            end
            if (gStrayReq && rspOp == OP_SUB && rspStrayRun != gRunId) begin
                MixRy = 1'b1;
                rspStrayRun = gRunId;
            end
        end
    end

    // Monitor: pops the scoreboard on every completion pulse
    exp_t monItem;
    always @(negedge Clk) begin
        if (Ry) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected Ry: got Ry=1 expected no pending result");
            end else begin
                monItem = sbq.pop_front();
                check("DataOut", DataOut, monItem.data);
                checkInt("Err at Ry", int'(Err), int'(monItem.err));
                checkInt("Busy at Ry", int'(Busy), 0);
                if (monItem.expLat >= 0)
                    checkInt("Ry latency", cycCount - monItem.startCyc, monItem.expLat);
            end
        end
        if (Busy)
            checkInt("enables one-hot", ($countones({AddEn, SubEn, ShiftEn, MixEn}) <= 1) ? 1 : 0, 1);
        if (AddEn | SubEn | ShiftEn | MixEn)
            checkInt("Inv during op", int'(Inv), int'(curMode));
    end

    task automatic waitRy(input string name, output bit dropped);
        dropped = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge Clk);
            if (Ry) return;
            if (!Busy) dropped = 1'b1;
        end
        checks++;
        errors++;
        $display("FAIL %s: got no Ry expected Ry within 5000 cycles", name);
    endtask

    task automatic pushExp(input bit mode, input logic [DW-1:0] din, input int um,
                           input bit stray, input bit timed);
        exp_t it;
        it.data     = refModel(mode, din, um);
        it.err      = stray;
        it.startCyc = cycCount + 1;
        it.expLat   = timed ? (8 * NR + 2) : -1;
        sbq.push_back(it);
    endtask

    // Called at a negedge; returns at the negedge where Ry is seen.
    task automatic runTxn(input string tag, input bit mode, input logic [DW-1:0] din,
                          input int um, input int dly, input bit dlyRand, input bit stray);
        bit dropped;
        int guard;
        guard = 0;
        while (Busy && guard < 5000) begin
            @(negedge Clk);
            guard++;
        end
        gUnitMode = um; gDelayMax = dly; gDelayRand = dlyRand;
        gStrayReq = stray; gRunId++; curMode = mode;
        Mode = mode; DataIn = din; En = 1'b1;
        pushExp(mode, din, um, stray, dly == 0);
        @(negedge Clk);
        // Now in LOAD: scramble the start inputs, which must have no effect
        En = 1'b0; Mode = 1'($urandom); DataIn = randBlock();
        waitRy(tag, dropped);
        checkInt({tag, " busy continuous"}, int'(dropped), 0);
    endtask

    initial begin
        bit dropped;
        logic [DW-1:0] d;
        Rst = 1'b1; En = 1'b0; Mode = 1'b0; DataIn = '0;
        AddRy = 1'b0; SubRy = 1'b0; ShiftRy = 1'b0; MixRy = 1'b0; ModifiedText = '0;
        repeat (3) @(negedge Clk);
        checkInt("reset Busy", int'(Busy), 0);
        checkInt("reset Ry", int'(Ry), 0);
        checkInt("reset enables", int'({AddEn, SubEn, ShiftEn, MixEn}), 0);
        checkInt("reset SelKey", int'(SelKey), 0);
        checkInt("reset Inv/Err", int'({Inv, Err}), 0);
        check("reset Text", Text, '0);
        check("reset DataOut", DataOut, '0);
        Rst = 1'b0;

        // Encrypt with identity units and a known block
        runTxn("enc identity", 1'b0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1, 0, 1'b0, 1'b0);
        // Decrypt with increment units from zero: 4*NR increments
        runTxn("dec increment", 1'b1, '0, 2, 0, 1'b0, 1'b0);
        check("dec increment value", DataOut, DW'(4 * NR));
        // Every ready delayed by three cycles
        runTxn("enc delayed", 1'b0, randBlock(), 2, 3, 1'b0, 1'b0);
        // Stray MixRy during SUB, then a clean run must clear Err
        runTxn("enc stray", 1'b0, randBlock(), 0, 0, 1'b0, 1'b1);
        runTxn("dec after stray", 1'b1, randBlock(), 0, 1, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            runTxn("random", 1'($urandom), randBlock(), (($urandom_range(3, 0) == 0) ? 2 : 0),
                   int'($urandom_range(3, 0)), 1'b1, 1'($urandom_range(3, 0) == 0));
        end

        // En held high across a run: restart only from IDLE after Ry
        d = randBlock();
        gUnitMode = 0; gDelayMax = 0; gDelayRand = 1'b0; gStrayReq = 1'b0; gRunId++;
        curMode = 1'b0; Mode = 1'b0; DataIn = d; En = 1'b1;
        pushExp(1'b0, d, 0, 1'b0, 1'b1);
        waitRy("hold first", dropped);
        checkInt("hold Busy at Ry", int'(Busy), 0);
        pushExp(1'b0, d, 0, 1'b0, 1'b1);
        @(negedge Clk);
        checkInt("hold restart Busy", int'(Busy), 1);
        En = 1'b0;
        waitRy("hold second", dropped);

        // Reset during a MIX op, then start on the very next cycle
        gUnitMode = 0; gDelayMax = 2; gDelayRand = 1'b0; gStrayReq = 1'b0; gRunId++;
        curMode = 1'b1; Mode = 1'b1; DataIn = randBlock(); En = 1'b1;
        @(negedge Clk);
        En = 1'b0;
        for (int i = 0; i < 200 && !MixEn; i++) @(negedge Clk);
        checkInt("reached MIX", int'(MixEn), 1);
        Rst = 1'b1;
        @(negedge Clk);
        checkInt("midrst Busy", int'(Busy), 0);
        checkInt("midrst Ry", int'(Ry), 0);
        checkInt("midrst enables", int'({AddEn, SubEn, ShiftEn, MixEn}), 0);
        checkInt("midrst SelKey/Inv/Err", int'({SelKey, Inv, Err}), 0);
        check("midrst Text", Text, '0);
        check("midrst DataOut", DataOut, '0);
        Rst = 1'b0;
        runTxn("after reset", 1'b0, randBlock(), 0, 0, 1'b0, 1'b0);

        repeat (5) @(negedge Clk);
        checkInt("scoreboard drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
